alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised N-bit ALU that replaces the bit-sliced combinational ALU.
- Two-stage pipelined datapath with a valid/ready handshake on both sides.
- The adder is split at LO_WIDTH: stage 1 computes the low half and its carry, and stage 2 completes the high half.
- Produces the result plus negative, zero, overflow and carry flags for the EX stage of the processor. Ops that may stall (backpressure) are supported.

Parameters:
- WIDTH, 64, operand/result width in bits; must be even and at least 4.
- LO_WIDTH, WIDTH/2, width of the stage-1 low adder slice; must satisfy 1 <= LO_WIDTH < WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream has an operation.
- in_ready  output  1  block accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  operation select.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  operation result.
- negative  output  1  result[WIDTH-1].
- zero  output  1  result == 0.
- overflow  output  1  signed overflow; add/sub only.
- carry_out  output  1  adder carry out; add/sub only.

Behaviour:
- Op encoding:
  - 000: result = B.
  - 010: A+B.
  - 011: A-B, computed as A + ~B + 1.
  - 100: A&B.
  - 101: A|B.
  - 110: A^B.
  - 001 and 111: result = 0, and all flags 0 except zero=1.
- Reset (reset=0, async): both stage-valid bits clear, out_valid=0, and result and all flags are 0. in_ready=1 while reset is held low and on the first edge after release.
- Reset mid-operation: in-flight ops are discarded; no output appears for them.
- Transfer rules:
  - An input transfer occurs on a clk edge when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stage 1 (captured on input transfer):
  - Registers A_hi, B'_hi (B or ~B), the op, and the low-half sum A[LO-1:0] + B'[LO-1:0] + cin (cin=1 for sub) together with its carry c_lo.
  - Also registers the low halves of the logic results, or the full logic results, as the implementation chooses.
  - s1_valid is set by an input transfer and cleared when stage 1 moves to stage 2 with no new input.
- Stage 2:
  - Computes the high-half sum A_hi + B'_hi + c_lo and concatenates it with the low half.
  - carry_out = carry from the MSB.
  - overflow = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]).
  - Registers result and flags; out_valid = s2_valid.
- Flags: negative and zero are computed from the final result for every op. carry_out and overflow are 0 for every op other than 010/011.
- Flow control:
  - s2_free = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_free.
  - Stage 1 moves to stage 2 when s1_valid && s2_free.
  - in_ready is combinational from out_ready; there is no combinational path from in_valid to out_valid.
- Latency and throughput: 2 cycles from input transfer to out_valid. Throughput is 1 op/cycle when out_ready=1.
- Stall: while out_valid && !out_ready, result and flags hold stable. Stage 1 may hold one further op, after which in_ready=0.
- Simultaneous events: in the same cycle an output transfer, a stage-1-to-stage-2 advance and a new input transfer may all occur. No op is dropped or duplicated.
- Ordering: ops complete strictly in order.
- Outputs while out_valid=0 hold their last value and are don't-care to the consumer.
- Unsigned wrap: add/sub results are modulo 2^WIDTH, e.g. 0 - 1 = all ones, with carry_out=0.

Test Plan:
- WIDTH=8, out_ready=1: add A=0x7F, B=0x01 -> 2 cycles later result=0x80, negative=1, overflow=1, carry_out=0, zero=0.
- WIDTH=8, sub A=0x05, B=0x05 -> result=0x00, zero=1, carry_out=1, overflow=0. Sub A=0x00, B=0x01 -> result=0xFF, negative=1, carry_out=0.
- WIDTH=64, add A=0x00000000FFFFFFFF, B=1 -> result=0x0000000100000000; the low-to-high split carry propagates; carry_out=0.
- Logic ops, WIDTH=8, A=0xCC, B=0xAA:
  - and -> 0x88.
  - or -> 0xEE.
  - xor -> 0x66.
  - op=000 -> 0xAA.
  - op=111 -> 0x00 with zero=1.
  - carry_out=0 and overflow=0 for all of these.
- Backpressure: stream 4 back-to-back adds with out_ready=0 -> in_ready drops after the 2nd accept and result holds the 1st sum. Raising out_ready -> all 4 sums emerge in order, with no drops or duplicates.
- Assert reset low with 2 ops in flight -> out_valid=0 immediately (async) and outputs 0. After release, a new op completes normally in 2 cycles.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation and result handshake bundle for the two-stage ALU.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carried here; the ALU side is the slave modport.
// Ports: input side in_valid/in_ready/a/b/op, output side out_valid/out_ready/result
//        plus negative/zero/overflow/carry_out flags.
interface alu_pipe_if #(
  parameter int WIDTH = 64
);
  // input-side handshake and operands
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;

  // output-side handshake, result and flags
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  // master: the environment that issues ops and consumes results
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, negative, zero, overflow, carry_out
  );

  // slave: the ALU itself
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage WIDTH-bit ALU (pass B, add, sub, and, or, xor) with N/Z/V/C flags.
// Latency: 2 cycles from input transfer to out_valid; 1 op/cycle when out_ready is held high.
// Backpressure: a stalled stage 2 holds result/flags; stage 1 buffers one more op, then in_ready drops.
// Ports: clk (rising edge), reset (async, active low), bus (alu_pipe_if.slave: in_valid/in_ready,
//        a, b, op, out_valid/out_ready, result, negative, zero, overflow, carry_out).
module alu_pipe #(
  parameter int WIDTH    = 64,
  parameter int LO_WIDTH = WIDTH / 2
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);

  localparam int HI_WIDTH = WIDTH - LO_WIDTH;

  localparam logic [2:0] OP_PASS_B = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;

  generate
    if ((WIDTH < 4) || ((WIDTH % 2) != 0) || (LO_WIDTH < 1) || (LO_WIDTH >= WIDTH)) begin : g_bad_params
      $error("alu_pipe: WIDTH must be even and >= 4, and 1 <= LO_WIDTH < WIDTH");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  // Stage 1: high operand halves, low sum slice with its carry, and the full
  // non-arithmetic result (logic ops, pass-B, and the zero-result encodings).
  logic                s1_valid_q,  s1_valid_d;
  logic [2:0]          s1_op_q,     s1_op_d;
  logic [HI_WIDTH-1:0] s1_a_hi_q,   s1_a_hi_d;
  logic [HI_WIDTH-1:0] s1_b_hi_q,   s1_b_hi_d;
  logic [LO_WIDTH-1:0] s1_sum_lo_q, s1_sum_lo_d;
  logic                s1_c_lo_q,   s1_c_lo_d;
  logic [WIDTH-1:0]    s1_logic_q,  s1_logic_d;

  // Stage 2: registered result and flags presented to the consumer.
  logic                s2_valid_q,  s2_valid_d;
  logic [WIDTH-1:0]    result_q,    result_d;
  logic                negative_q,  negative_d;
  logic                zero_q,      zero_d;
  logic                overflow_q,  overflow_d;
  logic                carry_q,     carry_d;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic s2_free;
  logic in_ready;
  logic in_fire;
  logic s1_adv;

  // in_ready depends on out_ready combinationally so a full pipe can accept a
  // new op in the same cycle its oldest result leaves. Nothing here looks at
  // in_valid on the way to out_valid.
  always_comb begin
    s2_free  = !s2_valid_q || bus.out_ready;
    in_ready = !s1_valid_q || s2_free;
    in_fire  = bus.in_valid && in_ready;
    s1_adv   = s1_valid_q && s2_free;
  end

  // ---------------------------------------------------------------------------
  // Stage 1 datapath: operand inversion for sub, low adder slice, logic ops
  // ---------------------------------------------------------------------------
  logic                is_sub;
  logic [WIDTH-1:0]    b_eff;
  logic [LO_WIDTH:0]   lo_sum;
  logic [WIDTH-1:0]    logic_res;

  always_comb begin
    is_sub = (bus.op == OP_SUB);
    // Subtraction is A + ~B + 1: invert B here and inject the +1 as the
    // carry-in of the low slice, so both stages only ever add.
    b_eff  = is_sub ? ~bus.b : bus.b;
    lo_sum = {1'b0, bus.a[LO_WIDTH-1:0]} + {1'b0, b_eff[LO_WIDTH-1:0]}
           + {{LO_WIDTH{1'b0}}, is_sub};

    case (bus.op)
      OP_PASS_B: logic_res = bus.b;
      OP_AND:    logic_res = bus.a & bus.b;
      OP_OR:     logic_res = bus.a | bus.b;
      OP_XOR:    logic_res = bus.a ^ bus.b;
      // 001 and 111 are defined to produce zero; add/sub never use this path.
      default:   logic_res = '0;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_hi_d   = s1_a_hi_q;
    s1_b_hi_d   = s1_b_hi_q;
    s1_sum_lo_d = s1_sum_lo_q;
    s1_c_lo_d   = s1_c_lo_q;
    s1_logic_d  = s1_logic_q;

    if (in_fire) begin
      // A new op replaces whatever just advanced (or fills an empty slot).
      s1_valid_d  = 1'b1;
      s1_op_d     = bus.op;
      s1_a_hi_d   = bus.a[WIDTH-1:LO_WIDTH];
      s1_b_hi_d   = b_eff[WIDTH-1:LO_WIDTH];
      s1_sum_lo_d = lo_sum[LO_WIDTH-1:0];
      s1_c_lo_d   = lo_sum[LO_WIDTH];
      s1_logic_d  = logic_res;
    end else if (s1_adv) begin
      s1_valid_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 datapath: high adder slice, result select, flags
  // ---------------------------------------------------------------------------
  logic [HI_WIDTH:0]   hi_sum;
  logic [WIDTH-1:0]    sum;
  logic                is_arith;
  logic [WIDTH-1:0]    final_res;
  logic                a_msb;
  logic                b_msb;

  always_comb begin
    hi_sum    = {1'b0, s1_a_hi_q} + {1'b0, s1_b_hi_q} + {{HI_WIDTH{1'b0}}, s1_c_lo_q};
    sum       = {hi_sum[HI_WIDTH-1:0], s1_sum_lo_q};
    is_arith  = (s1_op_q == OP_ADD) || (s1_op_q == OP_SUB);
    final_res = is_arith ? sum : s1_logic_q;
    a_msb     = s1_a_hi_q[HI_WIDTH-1];
    // b_msb is already the inverted operand's sign for sub, so one overflow
    // rule covers both add and sub.
    b_msb     = s1_b_hi_q[HI_WIDTH-1];
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    negative_d = negative_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    carry_d    = carry_q;

    // When stage 2 can change, it becomes exactly whatever stage 1 holds.
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
    end

    // Result and flags only load on an advance, so they hold through stalls
    // and keep their last value while out_valid is low.
    if (s1_adv) begin
      result_d   = final_res;
      negative_d = final_res[WIDTH-1];
      zero_d     = (final_res == '0);
      overflow_d = is_arith && (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
      carry_d    = is_arith && hi_sum[HI_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_hi_q   <= '0;
      s1_b_hi_q   <= '0;
      s1_sum_lo_q <= '0;
      s1_c_lo_q   <= 1'b0;
      s1_logic_q  <= '0;
      s2_valid_q  <= 1'b0;
      result_q    <= '0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_hi_q   <= s1_a_hi_d;
      s1_b_hi_q   <= s1_b_hi_d;
      s1_sum_lo_q <= s1_sum_lo_d;
      s1_c_lo_q   <= s1_c_lo_d;
      s1_logic_q  <= s1_logic_d;
      s2_valid_q  <= s2_valid_d;
      result_q    <= result_d;
      negative_q  <= negative_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      carry_q     <= carry_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.result    = result_q;
  assign bus.negative  = negative_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: drives an 8-bit and a 64-bit alu_pipe with the same op stream and
// checks both against an arithmetic reference model plus hand-computed values.
// Inputs change 2 time units after the rising edge; outputs are read on the falling edge.
module tb_alu_pipe;

  localparam logic [2:0] OP_B   = 3'b000;
  localparam logic [2:0] OP_Z1  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_Z7  = 3'b111;

  typedef struct {
    logic [63:0] res;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
    int          stamp;   // edge number on which the op was accepted
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [2:0]  op_in;
  logic        rdy_man;
  logic        rdy_pat;
  logic        auto_rdy;
  logic        out_ready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int nsend  = 0;

  exp_t sb [2][$];
  int   pushes  [2];
  int   pops    [2];
  int   flushed [2];

  assign out_ready = auto_rdy ? rdy_pat : rdy_man;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rdy_pat <= (cyc % 3) != 1;
  end

  alu_pipe_if #(.WIDTH(8))  if8  ();
  alu_pipe_if #(.WIDTH(64)) if64 ();

  assign if8.in_valid   = in_valid;
  assign if8.a          = a_in[7:0];
  assign if8.b          = b_in[7:0];
  assign if8.op         = op_in;
  assign if8.out_ready  = out_ready;
  assign if64.in_valid  = in_valid;
  assign if64.a         = a_in;
  assign if64.b         = b_in;
  assign if64.op        = op_in;
  assign if64.out_ready = out_ready;

  alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));
  alu_pipe #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .bus(if64));

  // Reference: plain unsigned/signed arithmetic at width w.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [2:0] op, input int w);
    exp_t e;
    logic [64:0] m, aa, bb, r;
    logic signed [67:0] sa, sb_s, sr, pw, half;
    m    = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & m;
    bb   = {1'b0, b} & m;
    pw   = 68'sd1 <<< w;
    half = pw >>> 1;
    sa   = $signed({3'b000, aa});
    sb_s = $signed({3'b000, bb});
    if (aa[w-1]) sa = sa - pw;
    if (bb[w-1]) sb_s = sb_s - pw;
    r   = '0;
    e.v = 1'b0;
    e.c = 1'b0;
    sr  = '0;
    case (op)
      OP_B:   r = bb;
      OP_ADD: begin
        r   = (aa + bb) & m;
        e.c = (aa + bb) > m;
        sr  = sa + sb_s;
        e.v = (sr >= half) || (sr < -half);
      end
      OP_SUB: begin
        r   = (aa - bb) & m;
        e.c = (aa >= bb);
        sr  = sa - sb_s;
        e.v = (sr >= half) || (sr < -half);
      end
      OP_AND: r = aa & bb;
      OP_OR:  r = aa | bb;
      OP_XOR: r = aa ^ bb;
      default: r = '0;
    endcase
    e.res   = r[63:0];
    e.n     = r[w-1];
    e.z     = (r == '0);
    e.stamp = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of one DUT against its scoreboard queue.
  task automatic monitor(input int k, input int w, input logic rdy, input logic vld,
                         input logic [63:0] res, input logic n, input logic z,
                         input logic v, input logic c);
    exp_t e;
    logic exp_vld;
    string p;
    p = $sformatf("dut%0d", w);
    if (!reset) begin
      flushed[k] += sb[k].size();
      sb[k].delete();
      chk($sformatf("%s reset in_ready", p), 64'(rdy), 64'd1);
      chk($sformatf("%s reset out_valid", p), 64'(vld), 64'd0);
      chk($sformatf("%s reset result", p), res, 64'd0);
      chk($sformatf("%s reset flags", p), 64'({n, z, v, c}), 64'd0);
      return;
    end
    // Two ops in flight means both stages are full: ready only if the head leaves.
    chk($sformatf("%s in_ready", p), 64'(rdy), 64'((sb[k].size() < 2) || out_ready));
    exp_vld = (sb[k].size() > 0) && (cyc >= sb[k][0].stamp + 1);
    chk($sformatf("%s out_valid", p), 64'(vld), 64'(exp_vld));
    if (vld && (sb[k].size() > 0)) begin
      e = sb[k][0];
      chk($sformatf("%s result", p), res, e.res);
      chk($sformatf("%s negative", p), 64'(n), 64'(e.n));
      chk($sformatf("%s zero", p), 64'(z), 64'(e.z));
      chk($sformatf("%s overflow", p), 64'(v), 64'(e.v));
      chk($sformatf("%s carry_out", p), 64'(c), 64'(e.c));
      if (out_ready) begin
        void'(sb[k].pop_front());
        pops[k]++;
      end
    end
    if (in_valid && rdy) begin
      e = model(a_in, b_in, op_in, w);
      e.stamp = cyc + 1;
      sb[k].push_back(e);
      pushes[k]++;
    end
  endtask

  always @(negedge clk) begin
    monitor(0, 8, if8.in_ready, if8.out_valid, 64'(if8.result),
            if8.negative, if8.zero, if8.overflow, if8.carry_out);
    monitor(1, 64, if64.in_ready, if64.out_valid, if64.result,
            if64.negative, if64.zero, if64.overflow, if64.carry_out);
  end

  // Present an op and hold it until both DUTs accept it (bounded).
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    op_in    = op;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      ok = if8.in_ready && if64.in_ready;
      @(posedge clk);
      #2;
    end
    checks++;
    if (ok) nsend++;
    else begin
      errors++;
      $display("FAIL send: op %b not accepted within 64 cycles, got in_ready=0, expected 1", op);
    end
  endtask

  // Issue a single op on an empty pipe and check it against literal values
  // exactly two edges after acceptance.
  task automatic lit(input string nm, input logic [63:0] a, input logic [63:0] b,
                     input logic [2:0] op, input bit wide, input logic [63:0] er,
                     input logic en, input logic ez, input logic ev, input logic ec);
    send(a, b, op);
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, " not valid after 1 edge"}, 64'(wide ? if64.out_valid : if8.out_valid), 64'd0);
    @(negedge clk);
    chk({nm, " valid after 2 edges"}, 64'(wide ? if64.out_valid : if8.out_valid), 64'd1);
    chk({nm, " result"}, wide ? if64.result : 64'(if8.result), er);
    chk({nm, " flags nzvc"},
        64'(wide ? {if64.negative, if64.zero, if64.overflow, if64.carry_out}
                 : {if8.negative, if8.zero, if8.overflow, if8.carry_out}),
        64'({en, ez, ev, ec}));
    @(posedge clk);
    #2;
  endtask

  logic [63:0] ta [8];
  logic [63:0] tb_v [8];
  logic [2:0]  to [8];

  initial begin
    exp_t m;
    int   p0;
    reset    = 1'b0;
    in_valid = 1'b0;
    a_in     = '0;
    b_in     = '0;
    op_in    = '0;
    rdy_man  = 1'b1;
    auto_rdy = 1'b0;
    pushes   = '{default: 0};
    pops     = '{default: 0};
    flushed  = '{default: 0};

    // Pin the reference model to hand-worked values.
    m = model(64'h7F, 64'h01, OP_ADD, 8);
    chk("model add7F res", m.res, 64'h80);
    chk("model add7F nzvc", 64'({m.n, m.z, m.v, m.c}), 64'b1010);
    m = model(64'h0, 64'h1, OP_SUB, 64);
    chk("model sub0-1 res", m.res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model sub0-1 nzvc", 64'({m.n, m.z, m.v, m.c}), 64'b1000);
    m = model(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, OP_ADD, 64);
    chk("model add min+min nzvc", 64'({m.n, m.z, m.v, m.c}), 64'b0111);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready dut8", 64'(if8.in_ready), 64'd1);
    chk("reset out_valid dut64", 64'(if64.out_valid), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Arithmetic and logic vectors, one at a time.
    lit("add 7F+01",  64'h7F, 64'h01, OP_ADD, 1'b0, 64'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    lit("sub 05-05",  64'h05, 64'h05, OP_SUB, 1'b0, 64'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    lit("sub 00-01",  64'h00, 64'h01, OP_SUB, 1'b0, 64'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    lit("and CC,AA",  64'hCC, 64'hAA, OP_AND, 1'b0, 64'h88, 1'b1, 1'b0, 1'b0, 1'b0);
    lit("or CC,AA",   64'hCC, 64'hAA, OP_OR,  1'b0, 64'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
    lit("xor CC,AA",  64'hCC, 64'hAA, OP_XOR, 1'b0, 64'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("passB",      64'hCC, 64'hAA, OP_B,   1'b0, 64'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    lit("op111",      64'hCC, 64'hAA, OP_Z7,  1'b0, 64'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    lit("op001",      64'hCC, 64'hAA, OP_Z1,  1'b0, 64'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    lit("add64 split carry", 64'h0000_0000_FFFF_FFFF, 64'h1, OP_ADD, 1'b1,
        64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("sub64 0-1", 64'h0, 64'h1, OP_SUB, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure: two ops fill the pipe, the third waits, first sum holds.
    rdy_man = 1'b0;
    p0 = pops[0];
    send(64'd10, 64'd20, OP_ADD);
    send(64'd30, 64'd40, OP_ADD);
    a_in = 64'd50;
    b_in = 64'd60;
    op_in = OP_ADD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp in_ready low", 64'(if8.in_ready), 64'd0);
      chk("bp out_valid held", 64'(if8.out_valid), 64'd1);
      chk("bp first sum held", 64'(if8.result), 64'h1E);
      @(posedge clk);
      #2;
    end
    rdy_man = 1'b1;
    send(64'd50, 64'd60, OP_ADD);
    send(64'd70, 64'd80, OP_ADD);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("bp four results out", 64'(pops[0] - p0), 64'd4);

    // Streamed mixed ops with a periodic out_ready stall.
    ta   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_8000_0000,
             64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0000, 64'hF0F0_F0F0_0F0F_0F0F,
             64'h0, 64'hDEAD_BEEF_0000_0081};
    tb_v = '{64'h1, 64'h1, 64'h0000_0000_8000_0000,
             64'h0FED_CBA9_8765_4321, 64'h1, 64'h0FF0_0FF0_0FF0_0FF0,
             64'h0, 64'hDEAD_BEEF_0000_0081};
    to   = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_XOR, OP_SUB, OP_SUB};
    auto_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send(ta[i], tb_v[i], to[i]);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    auto_rdy = 1'b0;

    // Reset with two ops in flight.
    rdy_man = 1'b0;
    send(64'd1, 64'd2, OP_ADD);
    send(64'd3, 64'd4, OP_ADD);
    in_valid = 1'b0;
    chk("pre-reset out_valid", 64'(if8.out_valid), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("async reset out_valid dut8", 64'(if8.out_valid), 64'd0);
    chk("async reset out_valid dut64", 64'(if64.out_valid), 64'd0);
    chk("async reset result dut8", 64'(if8.result), 64'd0);
    chk("async reset result dut64", if64.result, 64'd0);
    chk("async reset flags dut8",
        64'({if8.negative, if8.zero, if8.overflow, if8.carry_out}), 64'd0);
    chk("async reset in_ready", 64'(if8.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #2;
    reset   = 1'b1;
    rdy_man = 1'b1;
    @(negedge clk);
    chk("no output for discarded ops", 64'(if8.out_valid), 64'd0);
    @(posedge clk);
    #2;
    lit("post-reset add", 64'h40, 64'h40, OP_ADD, 1'b0, 64'h80, 1'b1, 1'b0, 1'b1, 1'b0);

    repeat (4) @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("sb%0d drained", k), 64'(sb[k].size()), 64'd0);
      chk($sformatf("sb%0d no drop/dup", k), 64'(pushes[k]), 64'(pops[k] + flushed[k]));
      chk($sformatf("sb%0d accepts", k), 64'(pushes[k]), 64'(nsend));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
